// File: rtl/bnn_conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bnn_conv_sequencer                                           |
// | Description : BNN configuration registers plus a row-serial XNOR-popcount  |
// |               sequencer that stalls Execute while BCNV/BNN is in flight.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bnn_conv_sequencer #(
    parameter int XLEN     = 32,
    parameter int MS_MAX   = 5,
    parameter int MS_RESET = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ms_WE,
    input  logic            at_WE,
    input  logic [XLEN-1:0] cfg_data,
    input  logic            start,
    input  logic            en_threshold,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [2:0]      ms_q,
    output logic [5:0]      at_q
);

    localparam int         c_ACC_W = $clog2(MS_MAX * MS_MAX + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic               r_en_thr;
    logic [2:0]         r_ms;
    logic [2:0]         r_row;
    logic [c_ACC_W-1:0] r_acc;
    logic [XLEN-1:0]    r_result;
    logic [XLEN-1:0]    r_prev_result;
    logic [2:0]         r_ms_cfg;
    logic [5:0]         r_at_cfg;

    logic               w_accept;
    logic               w_cfg_ok;
    logic               w_last;
    logic [5:0]         w_shift;
    logic [5:0]         w_sq;
    logic [XLEN-1:0]    w_a_sh;
    logic [XLEN-1:0]    w_b_sh;
    logic [MS_MAX-1:0]  w_mask;
    logic [MS_MAX-1:0]  w_match;
    logic [c_ACC_W-1:0] w_pop;
    logic [c_ACC_W-1:0] w_acc_next;
    logic [XLEN-1:0]    w_result;
    logic               w_unused;

    assign w_accept = (r_state == c_IDLE) && start && !flush;
    assign w_cfg_ok = (r_state == c_IDLE) && !start;
    assign w_last   = (r_row == (r_ms - 3'd1));

    // Current row is brought down to bit 0, then only ms bits are compared.
    assign w_shift  = {3'b000, r_row} * {3'b000, r_ms};
    assign w_sq     = {3'b000, r_ms} * {3'b000, r_ms};
    assign w_a_sh   = r_a >> w_shift;
    assign w_b_sh   = r_b >> w_shift;
    assign w_mask   = ~({MS_MAX{1'b1}} << r_ms);
    assign w_match  = ~(w_a_sh[MS_MAX-1:0] ^ w_b_sh[MS_MAX-1:0]) & w_mask;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < MS_MAX; i++) begin
            w_pop = w_pop + c_ACC_W'(w_match[i]);
        end
    end

    assign w_acc_next = r_acc + w_pop;

    // Raw score 2*acc - ms*ms wraps naturally into two's complement at XLEN.
    assign w_result = r_en_thr ?
                      XLEN'(8'(w_acc_next) >= 8'(r_at_cfg)) :
                      (XLEN'({w_acc_next, 1'b0}) - XLEN'(w_sq));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_next = c_RUN;
            c_RUN: begin
                if (flush)       w_state_next = c_IDLE;
                else if (w_last) w_state_next = c_DONE;
            end
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_en_thr      <= 1'b0;
            r_ms          <= '0;
            r_row         <= '0;
            r_acc         <= '0;
            r_result      <= '0;
            r_prev_result <= '0;
            r_ms_cfg      <= 3'(MS_RESET);
            r_at_cfg      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cfg_ok && ms_WE && (cfg_data[2:0] != 3'd0)) begin
                r_ms_cfg <= (cfg_data[2:0] > 3'(MS_MAX)) ? 3'(MS_MAX) : cfg_data[2:0];
            end
            if (w_cfg_ok && at_WE) begin
                r_at_cfg <= cfg_data[5:0];
            end
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_en_thr <= en_threshold;
                        r_ms     <= r_ms_cfg;
                        r_acc    <= '0;
                        r_row    <= '0;
                    end
                end
                c_RUN: begin
                    if (!flush) begin
                        r_acc <= w_acc_next;
                        r_row <= r_row + 3'd1;
                        if (w_last) begin
                            r_prev_result <= r_result;
                            r_result      <= w_result;
                        end
                    end
                end
                c_DONE: begin
                    // Result is published on entry to DONE; a flush here takes it back.
                    if (flush) r_result <= r_prev_result;
                end
                default: ;
            endcase
        end
    end

    assign stall  = w_accept || (r_state == c_RUN);
    assign busy   = (r_state != c_IDLE);
    assign done   = (r_state == c_DONE) && !flush;
    assign result = r_result;
    assign ms_q   = r_ms_cfg;
    assign at_q   = r_at_cfg;

    assign w_unused = &{1'b0, cfg_data[XLEN-1:6], w_a_sh[XLEN-1:MS_MAX], w_b_sh[XLEN-1:MS_MAX]};

endmodule
`default_nettype wire

// File: tb/tb_bnn_conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bnn_conv_sequencer                                        |
// | Description : Self-checking bench for bnn_conv_sequencer with a reference  |
// |               model of the configuration and convolution arithmetic.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bnn_conv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ms_WE = 1'b0;
    logic        at_WE = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        start = 1'b0;
    logic        en_threshold = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  ms_q;
    logic [5:0]  at_q;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_ms     = 3;
    int          m_at     = 0;
    logic [31:0] m_result = '0;

    bnn_conv_sequencer #(.XLEN(32), .MS_MAX(5), .MS_RESET(3)) dut (
        .clk(clk), .reset(reset), .ms_WE(ms_WE), .at_WE(at_WE),
        .cfg_data(cfg_data), .start(start), .en_threshold(en_threshold),
        .flush(flush), .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy),
        .done(done), .result(result), .ms_q(ms_q), .at_q(at_q)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Count agreeing bit pairs over an ms x ms matrix stored row-major in the low bits.
    function automatic int model_acc(input logic [31:0] a, input logic [31:0] b, input int ms);
        int acc = 0;
        for (int r = 0; r < ms; r++)
            for (int c = 0; c < ms; c++)
                if (a[r*ms + c] == b[r*ms + c]) acc++;
        return acc;
    endfunction

    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input int ms, input logic en, input int at);
        int acc = model_acc(a, b, ms);
        if (en) return (acc >= at) ? 32'd1 : 32'd0;
        return 32'(2*acc - ms*ms);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic mwe, input logic awe, input logic [31:0] d);
        ms_WE = mwe; at_WE = awe; cfg_data = d;
        next_cycle();
        ms_WE = 1'b0; at_WE = 1'b0;
        if (mwe && d[2:0] != 3'd0) m_ms = (d[2:0] > 3'd5) ? 5 : int'(d[2:0]);
        if (awe) m_at = int'(d[5:0]);
        check_eq("cfg_ms_q", 32'(ms_q), 32'(m_ms));
        check_eq("cfg_at_q", 32'(at_q), 32'(m_at));
    endtask

    // Holds start like a stalled instruction until it leaves Execute after DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic en,
                          input logic mid_ms_we);
        logic [31:0] exp = model_res(a, b, m_ms, en, m_at);
        op_a = a; op_b = b; en_threshold = en; start = 1'b1;
        for (int k = 0; k <= m_ms + 1; k++) begin
            if (mid_ms_we) begin
                ms_WE    = (k == 2);
                cfg_data = 32'd3;
            end
            @(negedge clk);
            if (k == 0) check_eq("busy_at_start", 32'(busy), 32'd0);
            check_eq("stall", 32'(stall), 32'(k <= m_ms));
            if (k == m_ms + 1) begin
                check_eq("done", 32'(done), 32'd1);
                check_eq("result", result, exp);
            end else begin
                check_eq("no_early_done", 32'(done), 32'd0);
            end
            next_cycle();
        end
        start = 1'b0; ms_WE = 1'b0;
        m_result = exp;
        check_eq("idle_after_op", 32'(busy), 32'd0);
        check_eq("ms_q_kept", 32'(ms_q), 32'(m_ms));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        next_cycle();
        next_cycle();
        reset = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_ms_q", 32'(ms_q), 32'd3);
        check_eq("rst_at_q", 32'(at_q), 32'd0);

        run_op(32'h0, 32'h0, 1'b0, 1'b0);
        run_op(32'h0000_01FF, 32'h0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hABCD_E000, 1'b0, 1'b0);

        do_cfg(1'b0, 1'b1, 32'd5);
        run_op(32'h1F, 32'h0, 1'b1, 1'b0);
        run_op(32'h0F, 32'h0, 1'b1, 1'b0);

        do_cfg(1'b1, 1'b0, 32'd0);
        do_cfg(1'b1, 1'b0, 32'd7);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Reset in the middle of a ms=5 operation.
        op_a = 32'h1234_5678; op_b = 32'h0; en_threshold = 1'b0; start = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b1; start = 1'b0;
        next_cycle();
        reset = 1'b0;
        m_ms = 3; m_at = 0; m_result = '0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_stall", 32'(stall), 32'd0);
        check_eq("midrst_ms_q", 32'(ms_q), 32'd3);
        check_eq("midrst_result", result, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("midrst_no_done", 32'(done), 32'd0);
        end
        next_cycle();

        // Flush in the middle of a ms=4 operation, then a clean restart.
        do_cfg(1'b1, 1'b0, 32'd4);
        run_op(32'h0000_00A5, 32'h0000_0F0F, 1'b0, 1'b0);
        op_a = 32'hFFFF; op_b = 32'h0; start = 1'b1;
        next_cycle();
        next_cycle();
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        check_eq("flush_no_done", 32'(done), 32'd0);
        next_cycle();
        flush = 1'b0;
        check_eq("flush_busy", 32'(busy), 32'd0);
        check_eq("flush_result_kept", result, m_result);
        run_op(32'h0000_3C3C, 32'h0000_00FF, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] d = $urandom;
            case ($urandom_range(0, 3))
                0: do_cfg(1'b1, 1'b0, d);
                1: do_cfg(1'b0, 1'b1, {26'd0, 6'($urandom_range(0, 26))});
                2: do_cfg(1'b1, 1'b1, d);
                default: ;
            endcase
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bnn_conv_sequencer.md
Name: bnn_conv_sequencer

Overview:
- Multi-cycle execution unit and controller for the custom BNN instructions (opcode 7'b1111111).
- Holds the matrix-size and activation-threshold configuration written by BNNCMS/BNNCAT.
- Sequences a row-by-row XNOR-popcount over the binarized operands for BCNV/BNN, and stalls the pipeline while the instruction is held in Execute.
- Produces the write-back result for the Execute-stage register write (RegWE_E path).

Parameters:
- XLEN, 32, operand/result/config width.
- MS_MAX, 5, maximum matrix size; MS_MAX*MS_MAX must be <= XLEN.
- MS_RESET, 3, matrix size after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ms_WE  in  1  BNNCMS write strobe (Execute).
- at_WE  in  1  BNNCAT write strobe (Execute).
- cfg_data  in  XLEN  config value, from the immediate.
- start  in  1  BCNV/BNN instruction valid in Execute.
- en_threshold  in  1  1 = BNN (thresholded), 0 = BCNV (raw score).
- flush  in  1  kill the in-flight operation (misprediction).
- op_a  in  XLEN  binarized input operand (rs1 value).
- op_b  in  XLEN  binarized kernel operand (rs2 value).
- stall  out  1  hold Fetch/Decode/Execute.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle result-valid pulse.
- result  out  XLEN  registered result.
- ms_q  out  3  current matrix size.
- at_q  out  6  current threshold.

Behaviour:
- Reset values:
  - FSM = IDLE; ms_q = MS_RESET; at_q = 0.
  - result = 0; done = 0; busy = 0; stall = 0.
  - Internal accumulator and row counter = 0.
- Config writes:
  - Accepted only in IDLE with start low. Otherwise ignored.
  - ms_WE: cfg_data[2:0] = 0 is ignored (ms_q retained). Values > MS_MAX saturate to MS_MAX.
  - at_WE: at_q <= cfg_data[5:0].
  - ms_WE and at_WE in the same cycle: both apply.
  - A new ms_q or at_q is visible to a start in the following cycle.
- Row layout:
  - Row r (0..ms-1) occupies bits [r*ms +: ms] of both op_a and op_b.
  - Bits at and above ms*ms are ignored.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1 and flush=0:
    - Latch op_a, op_b, en_threshold and ms_q.
    - acc = 0, row = 0.
    - Go to RUN.
  - RUN, each cycle:
    - acc += popcount(~(a_row ^ b_row)) over ms bits.
    - row++.
    - When row == ms-1, go to DONE.
  - DONE:
    - Register the result.
    - done = 1 for exactly this cycle.
    - Go to IDLE unconditionally. start is ignored in DONE.
- stall is combinational: (IDLE & start & ~flush) | RUN. It is low in DONE, so the instruction leaves Execute at the end of DONE.
- Latency:
  - Start sampled in cycle 0; RUN occupies cycles 1..ms; done in cycle ms+1.
  - Total stall cycles = ms+1.
- Arithmetic (acc is 5 bits, range 0..25):
  - en_threshold = 0: result = sign-extended (2*acc - ms*ms), range -25..+25.
  - en_threshold = 1: result = {XLEN-1 zeros, (acc >= at_q)}.
- result holds its value until the next DONE. It is not cleared on start.
- start while in RUN is ignored (the held instruction keeps start high).
- flush:
  - In RUN or DONE: next state IDLE, no done pulse, result unchanged. stall drops in the cycle after flush.
  - In IDLE: suppresses acceptance of start.
- reset has priority over flush, start and config writes. Reset mid-RUN returns to IDLE with all reset values in the next cycle.

Test Plan:
- Reset; ms=3 (reset default); start with op_a=op_b=0x0, en_threshold=0 -> stall high for cycles 0..3, done in cycle 4, result=0x00000009.
- ms=3; op_a=0x000001FF, op_b=0x0, BCNV -> result=0xFFFFFFF7 (-9); bits above 8 toggled in op_a do not change the result.
- at_WE with cfg_data=5, ms=3, op_a=0x1F, op_b=0x0 (acc=4), BNN -> result=0. Then op_a=0xF (acc=5) -> result=1.
- ms_WE with cfg_data=0 -> ms_q stays 3. cfg_data=7 -> ms_q=5. op_a=op_b=0xFFFFFFFF -> result=25, done in cycle 6. ms_WE issued during RUN -> ms_q unchanged.
- Start with ms=5; assert reset in cycle 2 -> cycle 3: busy=0, stall=0, ms_q=3, result=0, no done pulse ever.
- Start with ms=4; flush in cycle 2 -> IDLE in cycle 3, no done, previous result retained. A new start in cycle 3 completes normally.
